// File: rtl/reg_file_io.sv
// Register file with SIZE general registers, two registered read ports and
// NPORTS memory-mapped bidirectional I/O ports with synchronisers and change flags.
module reg_file_io #(
    parameter int WIDTH  = 8,
    parameter int SIZE   = 16,
    parameter int NPORTS = 1,
    localparam int AW    = $clog2(SIZE + 2*NPORTS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WE,
    input  logic [AW-1:0]            WSEL,
    input  logic [WIDTH-1:0]         IN,
    input  logic [AW-1:0]            RSEL_A,
    input  logic [AW-1:0]            RSEL_B,
    output logic [WIDTH-1:0]         OUT_A,
    output logic [WIDTH-1:0]         OUT_B,
    inout  wire  [NPORTS*WIDTH-1:0]  PORT,
    output logic [NPORTS-1:0]        CHG
);

    logic [WIDTH-1:0] gp_reg [SIZE];
    logic [WIDTH-1:0] olat   [NPORTS];
    logic [WIDTH-1:0] dir    [NPORTS];
    logic [WIDTH-1:0] s1     [NPORTS];
    logic [WIDTH-1:0] s2     [NPORTS];

    logic [WIDTH-1:0] gp_nxt   [SIZE];
    logic [WIDTH-1:0] olat_nxt [NPORTS];
    logic [WIDTH-1:0] dir_nxt  [NPORTS];
    logic [WIDTH-1:0] port_val [NPORTS];
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic [NPORTS-1:0] chg_nxt;

    // Post-write view of all writable state; reads use it to get write-first bypass.
    always_comb begin
        gp_nxt   = gp_reg;
        olat_nxt = olat;
        dir_nxt  = dir;
        if (WE) begin
            for (int i = 0; i < SIZE; i++)
                if (int'(WSEL) == i) gp_nxt[i] = IN;
            for (int k = 0; k < NPORTS; k++) begin
                if (int'(WSEL) == SIZE + k)          olat_nxt[k] = IN;
                if (int'(WSEL) == SIZE + NPORTS + k) dir_nxt[k]  = IN;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NPORTS; k++)
            port_val[k] = (olat_nxt[k] & dir_nxt[k]) | (s2[k] & ~dir_nxt[k]);
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (int'(RSEL_A) == i) rd_a = gp_nxt[i];
            if (int'(RSEL_B) == i) rd_b = gp_nxt[i];
        end
        for (int k = 0; k < NPORTS; k++) begin
            if (int'(RSEL_A) == SIZE + k)          rd_a = port_val[k];
            if (int'(RSEL_B) == SIZE + k)          rd_b = port_val[k];
            if (int'(RSEL_A) == SIZE + NPORTS + k) rd_a = dir_nxt[k];
            if (int'(RSEL_B) == SIZE + NPORTS + k) rd_b = dir_nxt[k];
        end
    end

    // A pending input edge in S1 vs S2 sets the flag; only port-A reads acknowledge it.
    always_comb begin
        chg_nxt = CHG;
        for (int k = 0; k < NPORTS; k++) begin
            if (|((s1[k] ^ s2[k]) & ~dir[k]))
                chg_nxt[k] = 1'b1;
            else if (int'(RSEL_A) == SIZE + k)
                chg_nxt[k] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            gp_reg <= '{default: '0};
            olat   <= '{default: '0};
            dir    <= '{default: '0};
            s1     <= '{default: '0};
            s2     <= '{default: '0};
            OUT_A  <= '0;
            OUT_B  <= '0;
            CHG    <= '0;
        end else begin
            gp_reg <= gp_nxt;
            olat   <= olat_nxt;
            dir    <= dir_nxt;
            for (int k = 0; k < NPORTS; k++)
                s1[k] <= PORT[k*WIDTH +: WIDTH];
            s2     <= s1;
            OUT_A  <= rd_a;
            OUT_B  <= rd_b;
            CHG    <= chg_nxt;
        end
    end

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign PORT[k*WIDTH + i] = dir[k][i] ? olat[k][i] : 1'bz;
        end
    end

endmodule

// File: tb/tb_reg_file_io.sv
// Scoreboard bench for reg_file_io: stimulus pushes model expectations,
// a monitor pops and compares them one edge later.
module tb_reg_file_io;

    localparam int W  = 8;
    localparam int SZ = 16;
    localparam int NP = 2;
    localparam int AW = $clog2(SZ + 2*NP);
    localparam int NADDR = SZ + 2*NP;

    typedef struct packed {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [NP-1:0]   chg;
        logic [NP*W-1:0] pv;
        logic [NP*W-1:0] pm;
    } exp_t;

    logic clk = 1'b0;
    logic rst, we;
    logic [AW-1:0] wsel, rsel_a, rsel_b;
    logic [W-1:0] din, out_a, out_b;
    logic [NP-1:0] chg;
    wire  [NP*W-1:0] port;
    logic [NP*W-1:0] pin_val = '0;
    logic [NP*W-1:0] pin_en  = '0;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;

    logic [W-1:0] m_reg [SZ];
    logic [W-1:0] m_olat [NP], m_dir [NP], m_s1 [NP], m_s2 [NP];
    logic [NP-1:0] m_chg;
    logic [W-1:0] n_reg [SZ];
    logic [W-1:0] n_olat [NP], n_dir [NP];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NP*W; i++) begin : g_drv
        assign port[i] = pin_en[i] ? pin_val[i] : 1'bz;
    end

    reg_file_io #(.WIDTH(W), .SIZE(SZ), .NPORTS(NP)) dut (
        .CLK(clk), .RST(rst), .WE(we), .WSEL(wsel), .IN(din),
        .RSEL_A(rsel_a), .RSEL_B(rsel_b), .OUT_A(out_a), .OUT_B(out_b),
        .PORT(port), .CHG(chg)
    );

    // Reads see the location as it stands after this cycle's write.
    function automatic logic [W-1:0] mread(int a);
        if (a < SZ) return n_reg[a];
        if (a < SZ + NP) return (n_olat[a-SZ] & n_dir[a-SZ]) | (m_s2[a-SZ] & ~n_dir[a-SZ]);
        if (a < NADDR) return n_dir[a-SZ-NP];
        return '0;
    endfunction

    task automatic applyStimulus(input logic r, input logic w, input int wa, input logic [W-1:0] wd,
                                 input int ra, input int rb, input logic [NP*W-1:0] pv);
        exp_t e;
        logic [W-1:0] pin_now [NP];
        @(negedge clk);
        rst = r; we = w; wsel = AW'(wa); din = wd; rsel_a = AW'(ra); rsel_b = AW'(rb);
        pin_val = pv;
        for (int k = 0; k < NP; k++) begin
            pin_en[k*W +: W] = ~m_dir[k];
            pin_now[k] = (m_olat[k] & m_dir[k]) | (pv[k*W +: W] & ~m_dir[k]);
        end
        n_reg = m_reg; n_olat = m_olat; n_dir = m_dir;
        if (w) begin
            if (wa < SZ) n_reg[wa] = wd;
            else if (wa < SZ + NP) n_olat[wa-SZ] = wd;
            else if (wa < NADDR) n_dir[wa-SZ-NP] = wd;
        end
        e = '0;
        if (r) begin
            m_reg = '{default: '0}; m_olat = '{default: '0}; m_dir = '{default: '0};
            m_s1 = '{default: '0}; m_s2 = '{default: '0}; m_chg = '0;
        end else begin
            e.a = mread(ra);
            e.b = mread(rb);
            for (int k = 0; k < NP; k++) begin
                if (((m_s1[k] ^ m_s2[k]) & ~m_dir[k]) != '0) m_chg[k] = 1'b1;
                else if (ra == SZ + k) m_chg[k] = 1'b0;
                e.pm[k*W +: W] = n_dir[k] & m_dir[k];
                e.pv[k*W +: W] = n_olat[k];
            end
            m_s2 = m_s1;
            m_s1 = pin_now;
            m_reg = n_reg; m_olat = n_olat; m_dir = n_dir;
        end
        e.chg = m_chg;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (out_a === e.a) passes++;
        else $display("[TB] FAIL out_a got %h expected %h at %0t", out_a, e.a, $time);
        checks++;
        if (out_b === e.b) passes++;
        else $display("[TB] FAIL out_b got %h expected %h at %0t", out_b, e.b, $time);
        checks++;
        if (chg === e.chg) passes++;
        else $display("[TB] FAIL chg got %b expected %b at %0t", chg, e.chg, $time);
        checks++;
        if ((port & e.pm) === (e.pv & e.pm)) passes++;
        else $display("[TB] FAIL port got %h expected %h mask %h at %0t", port, e.pv, e.pm, $time);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    initial begin
        int wa, ra, rb;
        logic [NP*W-1:0] pv;
        m_reg = '{default: '0}; m_olat = '{default: '0}; m_dir = '{default: '0};
        m_s1 = '{default: '0}; m_s2 = '{default: '0}; m_chg = '0;
        rst = 1'b1; we = 1'b0; wsel = '0; din = '0; rsel_a = '0; rsel_b = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        applyStimulus(1, 0, 0, 0, 0, 0, '0);
        for (int a = 0; a < (1 << AW); a++) applyStimulus(0, 0, 0, 0, a, (1 << AW) - 1 - a, '0);

        applyStimulus(0, 1, 3, 8'h5A, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, 3, 3, '0);
        applyStimulus(0, 1, 5, 8'hC3, 5, 5, '0);

        applyStimulus(0, 1, SZ + NP, 8'hFF, 0, 0, '0);
        applyStimulus(0, 1, SZ, 8'h96, SZ, SZ, '0);
        applyStimulus(0, 0, 0, 0, SZ, SZ + NP, '0);
        applyStimulus(0, 1, SZ + NP, 8'h0F, SZ, SZ, '0);
        applyStimulus(0, 0, 0, 0, SZ, 0, '0);
        applyStimulus(0, 1, SZ, 8'hAB, SZ, SZ, '0);
        applyStimulus(0, 1, SZ + NP, 8'h00, 0, 0, '0);

        for (int c = 0; c < 5; c++) applyStimulus(0, 0, 0, 0, 0, SZ, 16'h003C);
        for (int c = 0; c < 2; c++) applyStimulus(0, 0, 0, 0, SZ, SZ, 16'h003C);
        applyStimulus(0, 0, 0, 0, SZ, 0, 16'h00C3);
        for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, 0, SZ, SZ, 16'h00C3);

        applyStimulus(0, 1, NADDR, 8'hFF, NADDR, 2, 16'h00C3);
        applyStimulus(0, 0, 0, 0, NADDR, NADDR, 16'h00C3);
        applyStimulus(1, 1, 2, 8'hFF, 2, 2, 16'h00C3);
        applyStimulus(0, 0, 0, 0, 2, 3, 16'h00C3);

        pv = '0;
        for (int c = 0; c < 3000; c++) begin
            wa = ($urandom % 4 == 0) ? int'($urandom_range(0, (1 << AW) - 1)) : int'($urandom_range(0, NADDR - 1));
            ra = ($urandom % 3 == 0) ? wa : int'($urandom_range(0, NADDR));
            rb = ($urandom % 3 == 0) ? ra : int'($urandom_range(0, NADDR));
            if ($urandom % 4 == 0) pv = NP*W'($urandom);
            applyStimulus(($urandom % 100) == 0, $urandom % 2 == 0, wa, W'($urandom), ra, rb, pv);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() == 0) passes++;
        else $display("[TB] FAIL scoreboard_drain got %0d left expected 0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
